// File: rtl/psg_seq_pkg.sv
// Shared types and bus constants for the TurboSound PSG write sequencer.
package psg_seq_pkg;

  typedef enum logic [2:0] {
    StIdle, StStart, StSel, StAddr, StData, StRaddr, StRsel, StFin
  } seq_state_e;

  localparam logic [7:0] SEL_AY1 = 8'hFF;
  localparam logic [7:0] SEL_AY2 = 8'hFE;

  // Bus codes as {bdir, bc1}
  localparam logic [1:0] LATCH = 2'b11;
  localparam logic [1:0] WRITE = 2'b10;
  localparam logic [1:0] INACT = 2'b00;

  function automatic logic [7:0] sel_byte(input logic chip);
    return chip ? SEL_AY2 : SEL_AY1;
  endfunction

endpackage

// File: rtl/psg_write_sequencer_snoop.sv
// Tracks the CPU's chip selection and per-chip latched register address.
module psg_cpu_snoop
  import psg_seq_pkg::*;
(
  input  logic       clk7,
  input  logic       reset_n,
  input  logic       cpu_bdir,
  input  logic       cpu_bc1,
  input  logic [7:0] cpu_din,
  output logic       cpu_act,
  output logic       sh_sel,
  output logic [7:0] sh_addr0,
  output logic [7:0] sh_addr1
);

  assign cpu_act = cpu_bdir | cpu_bc1;

  // sh_sel = 1 means AY1 is selected (select byte bit 0)
  always_ff @(posedge clk7 or negedge reset_n) begin
    if (!reset_n) begin
      sh_sel   <= 1'b1;
      sh_addr0 <= 8'h00;
      sh_addr1 <= 8'h00;
    end else if (cpu_bdir && cpu_bc1) begin
      if (cpu_din[7:1] == SEL_AY1[7:1]) begin
        sh_sel <= cpu_din[0];
      end else if (sh_sel) begin
        sh_addr0 <= cpu_din;
      end else begin
        sh_addr1 <= cpu_din;
      end
    end
  end

endmodule

// File: rtl/psg_write_sequencer.sv
// Shares the PSG bus between the CPU (priority, pass-through) and queued register writes.
module psg_write_sequencer
  import psg_seq_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES    = 1
) (
  input  logic       clk7,
  input  logic       reset_n,
  input  logic       cpu_bdir,
  input  logic       cpu_bc1,
  input  logic [7:0] cpu_din,
  input  logic       q_valid,
  output logic       q_ready,
  input  logic       q_chip,
  input  logic [3:0] q_reg,
  input  logic [7:0] q_data,
  output logic       psg_bdir,
  output logic       psg_bc1,
  output logic [7:0] psg_din,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST    = 4'(GAP_CYCLES - 1);

  logic       cpu_act, sh_sel;
  logic [7:0] sh_addr0, sh_addr1;

  psg_cpu_snoop u_snoop (
    .clk7     (clk7),
    .reset_n  (reset_n),
    .cpu_bdir (cpu_bdir),
    .cpu_bc1  (cpu_bc1),
    .cpu_din  (cpu_din),
    .cpu_act  (cpu_act),
    .sh_sel   (sh_sel),
    .sh_addr0 (sh_addr0),
    .sh_addr1 (sh_addr1)
  );

  seq_state_e state_q, nxt_state;
  logic       chip_q, same_q, hold_q, gap_q, busy_q, done_q;
  logic [3:0] reg_q, cnt_q;
  logic [7:0] data_q, din_q, ent_din;
  logic [1:0] code_q, ent_code;
  logic       same, in_step, enter_step;

  // Chip 0 (AY1) corresponds to sh_sel = 1
  assign same    = (chip_q != sh_sel);
  assign in_step = (state_q != StIdle) && (state_q != StStart) && (state_q != StFin);
  assign enter_step = !cpu_act && ((state_q == StStart) ||
                      (in_step && !hold_q && gap_q && (cnt_q == GAP_LAST)));

  always_comb begin
    nxt_state = StFin;
    unique case (state_q)
      StStart: nxt_state = same ? StAddr : StSel;
      StSel:   nxt_state = StAddr;
      StAddr:  nxt_state = StData;
      StData:  nxt_state = StRaddr;
      StRaddr: nxt_state = same_q ? StFin : StRsel;
      default: nxt_state = StFin;
    endcase
  end

  always_comb begin
    ent_code = INACT;
    ent_din  = 8'h00;
    unique case (nxt_state)
      StSel:   begin ent_code = LATCH; ent_din = sel_byte(chip_q); end
      StAddr:  begin ent_code = LATCH; ent_din = {4'h0, reg_q}; end
      StData:  begin ent_code = WRITE; ent_din = data_q; end
      StRaddr: begin ent_code = LATCH; ent_din = chip_q ? sh_addr1 : sh_addr0; end
      StRsel:  begin ent_code = LATCH; ent_din = sh_sel ? SEL_AY1 : SEL_AY2; end
      default: begin ent_code = INACT; ent_din = 8'h00; end
    endcase
  end

  always_ff @(posedge clk7 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      chip_q  <= 1'b0;
      reg_q   <= 4'h0;
      data_q  <= 8'h00;
      same_q  <= 1'b0;
      hold_q  <= 1'b0;
      gap_q   <= 1'b0;
      cnt_q   <= 4'h0;
      code_q  <= INACT;
      din_q   <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (q_valid) begin
            chip_q  <= q_chip;
            reg_q   <= q_reg;
            data_q  <= q_data;
            busy_q  <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: same_q <= same;
        StFin: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          if (cpu_act) begin
            // CPU pre-empts: drop the step, restart once the bus has been quiet
            hold_q <= 1'b1;
            gap_q  <= 1'b0;
            cnt_q  <= 4'h0;
            code_q <= INACT;
            din_q  <= 8'h00;
          end else if (hold_q) begin
            if (cnt_q == GAP_LAST) begin
              hold_q  <= 1'b0;
              cnt_q   <= 4'h0;
              state_q <= StStart;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end else if (!gap_q) begin
            if (cnt_q == STROBE_LAST) begin
              gap_q  <= 1'b1;
              cnt_q  <= 4'h0;
              code_q <= INACT;
              din_q  <= 8'h00;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
      endcase
      if (enter_step) begin
        cnt_q <= 4'h0;
        gap_q <= 1'b0;
        if (nxt_state == StFin) begin
          state_q <= StFin;
          done_q  <= 1'b1;
        end else begin
          state_q <= nxt_state;
          code_q  <= ent_code;
          din_q   <= ent_din;
        end
      end
    end
  end

  assign q_ready  = (state_q == StIdle);
  assign busy     = busy_q;
  assign done     = done_q;
  assign psg_bdir = cpu_act ? cpu_bdir : code_q[1];
  assign psg_bc1  = cpu_act ? cpu_bc1  : code_q[0];
  assign psg_din  = cpu_act ? cpu_din  : din_q;

endmodule
